// File: rtl/address_transmitter.sv
// I2C master address phase: START, 8 address/RW bits, ACK sample, then HOLD or STOP.
// SCL is built from CLK_DIV-cycle quarters; a released-but-low SCL stretches the quarter.
module address_transmitter #(
  parameter int CLK_DIV = 250
) (
  input  logic       FPGA_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [6:0] I2C_addr,
  input  logic       rw,
  input  logic       release_req,
  input  logic       SDA,
  input  logic       SCL,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       acked,
  output logic       nack
);

  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    IDLE, START, SHIFT, ACK, HOLD, STOP
  } state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0]    phase;
  logic [7:0]    shreg;
  logic [2:0]    bitcnt;
  logic          tick, en, step, qlast;

  assign tick = cnt == LAST;
  assign busy = state != IDLE;

  always_comb begin
    state_n = state;
    scl_oe  = 1'b0;
    sda_oe  = 1'b0;
    qlast   = 1'b0;
    unique case (state)
      IDLE: begin end
      START: begin
        scl_oe = phase[0];
        sda_oe = 1'b1;
        qlast  = phase == 2'd1;
      end
      SHIFT: begin
        scl_oe = ~phase[1];
        sda_oe = ~shreg[7];
        qlast  = phase == 2'd3;
      end
      ACK: begin
        scl_oe = ~phase[1];
        qlast  = phase == 2'd3;
      end
      HOLD: scl_oe = 1'b1;
      STOP: begin
        scl_oe = phase == 2'd0;
        sda_oe = phase != 2'd2;
        qlast  = phase == 2'd2;
      end
      default: begin end
    endcase
    // A released SCL that still reads low is a slave stretching the clock.
    en   = state != IDLE && state != HOLD && (scl_oe || SCL);
    step = en && tick;
    unique case (state)
      IDLE:  if (start) state_n = START;
      START: if (step && qlast) state_n = SHIFT;
      SHIFT: if (step && qlast && bitcnt == 3'd0) state_n = ACK;
      ACK:   if (step && qlast) state_n = acked ? HOLD : STOP;
      HOLD:  if (release_req) state_n = STOP;
      STOP:  if (step && qlast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge FPGA_clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      phase  <= 2'd0;
      shreg  <= 8'd0;
      bitcnt <= 3'd0;
      done   <= 1'b0;
      acked  <= 1'b0;
      nack   <= 1'b0;
    end else begin
      state <= state_n;
      done  <= (state == ACK && state_n == HOLD) ||
               (state == STOP && state_n == IDLE && nack);
      if (state == IDLE || state == HOLD) begin
        cnt   <= '0;
        phase <= 2'd0;
      end else if (step) begin
        cnt   <= '0;
        phase <= qlast ? 2'd0 : phase + 2'd1;
      end else if (en) begin
        cnt <= cnt + 1'b1;
      end
      if (state == IDLE && start) begin
        shreg  <= {I2C_addr, rw};
        bitcnt <= 3'd7;
      end
      if (state == SHIFT && step && qlast) begin
        shreg  <= {shreg[6:0], 1'b0};
        bitcnt <= bitcnt - 3'd1;
      end
      if (state == ACK && step && phase == 2'd2) begin
        acked <= ~SDA;
        nack  <= SDA;
      end
    end
  end

endmodule

// File: tb/tb_address_transmitter.sv
// Bench for address_transmitter: quarter-level waveform model, ACK/NACK,
// clock stretching, mid-transfer reset and ignored start/release.
module tb_address_transmitter;

  localparam int D = 4;

  logic       FPGA_clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] I2C_addr = 7'd0;
  logic       rw = 1'b0;
  logic       release_req = 1'b0;
  logic       SDA, SCL;
  logic       scl_oe, sda_oe, busy, done, acked, nack;
  logic       slave_low = 1'b0;
  logic       stretch_low = 1'b0;

  int checks = 0;
  int failures = 0;
  logic p_acked = 1'b0;
  logic p_nack = 1'b0;

  assign SDA = ~(sda_oe | slave_low);
  assign SCL = ~(scl_oe | stretch_low);

  always #5 FPGA_clk = ~FPGA_clk;

  address_transmitter #(.CLK_DIV(D)) dut (
    .FPGA_clk(FPGA_clk), .rst(rst), .start(start),
    .I2C_addr(I2C_addr), .rw(rw), .release_req(release_req),
    .SDA(SDA), .SCL(SCL), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .busy(busy), .done(done), .acked(acked), .nack(nack)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Which quarter a cycle (1 = first cycle after start accept) falls in,
  // given an s-cycle stretch inside quarter sq.
  function automatic int quarter_of(int c, int sq, int s);
    int k;
    k = c - 1;
    if (k < sq * D) return k / D;
    if (k < sq * D + D + s) return sq;
    return (k - s) / D;
  endfunction

  task automatic run_txn(input logic [6:0] a, input logic r,
                         input logic ack, input int sq, input int s,
                         input int rst_at, input int junk_at);
    logic [7:0] byte_v;
    logic [1:0] q[$];
    int nq, last, qi;
    byte_v = {a, r};
    q = {};
    q.push_back(2'b01);
    q.push_back(2'b11);
    for (int i = 7; i >= 0; i--)
      for (int j = 0; j < 4; j++) q.push_back({j < 2, ~byte_v[i]});
    for (int j = 0; j < 4; j++) q.push_back({j < 2, 1'b0});
    if (!ack) begin
      q.push_back(2'b11);
      q.push_back(2'b01);
      q.push_back(2'b00);
    end
    nq = q.size();
    last = nq * D + s;
    I2C_addr = a;
    rw = r;
    start = 1'b1;
    @(posedge FPGA_clk);
    #1;
    for (int c = 1; c <= last + 1; c++) begin
      if (c > 1) begin
        @(posedge FPGA_clk);
        #1;
      end
      start = 1'b0;
      release_req = 1'b0;
      if (c <= last) begin
        qi = quarter_of(c, sq, s);
        stretch_low = s > 0 && (c - 1) >= sq * D && (c - 1) < sq * D + s;
        slave_low = ack && qi >= 34 && qi <= 37;
        chk("wave", {scl_oe, sda_oe, busy, done}, {q[qi], 1'b1, 1'b0});
        if (qi < 36)
          chk("result_hold", {acked, nack}, {p_acked, p_nack});
        if (c == rst_at) begin
          #1 rst = 1'b1;
          #1;
          chk("rst_async", {scl_oe, sda_oe, busy, done, acked, nack}, 8'd0);
          #1 rst = 1'b0;
          stretch_low = 1'b0;
          slave_low = 1'b0;
          p_acked = 1'b0;
          p_nack = 1'b0;
          return;
        end
        if (c == junk_at) begin
          start = 1'b1;
          release_req = 1'b1;
          I2C_addr = 7'($urandom);
          rw = 1'($urandom);
        end
      end else begin
        stretch_low = 1'b0;
        slave_low = 1'b0;
        chk("done", {scl_oe, sda_oe, busy, done}, ack ? 4'b1011 : 4'b0001);
        chk("result", {acked, nack}, {ack, ~ack});
      end
    end
    p_acked = ack;
    p_nack = ~ack;
  endtask

  task automatic do_hold(input int n, input int junk);
    logic [1:0] sw [3];
    sw[0] = 2'b11;
    sw[1] = 2'b01;
    sw[2] = 2'b00;
    for (int i = 1; i <= n; i++) begin
      @(posedge FPGA_clk);
      #1;
      start = (i == junk);
      I2C_addr = 7'($urandom);
      chk("hold", {scl_oe, sda_oe, busy, done}, 4'b1010);
    end
    start = 1'b0;
    release_req = 1'b1;
    @(posedge FPGA_clk);
    #1;
    release_req = 1'b0;
    for (int c = 0; c < 3 * D; c++) begin
      if (c > 0) begin
        @(posedge FPGA_clk);
        #1;
      end
      chk("stop", {scl_oe, sda_oe, busy, done}, {sw[c / D], 2'b10});
    end
    @(posedge FPGA_clk);
    #1;
    chk("stop_idle", {scl_oe, sda_oe, busy, done}, 4'b0000);
    chk("stop_result", {acked, nack}, 2'b10);
    @(posedge FPGA_clk);
    #1;
    chk("idle_after", {scl_oe, sda_oe, busy, done}, 4'b0000);
  endtask

  initial begin
    logic ack;
    #2;
    chk("reset", {scl_oe, sda_oe, busy, done, acked, nack}, 8'd0);
    repeat (2) @(posedge FPGA_clk);
    #1;
    chk("reset_held", {scl_oe, sda_oe, busy, done, acked, nack}, 8'd0);
    rst = 1'b0;
    @(posedge FPGA_clk);
    #1;
    chk("idle", {scl_oe, sda_oe, busy, done}, 4'b0000);

    run_txn(7'h50, 1'b0, 1'b1, 0, 0, 0, 0);
    do_hold(5, 2);

    run_txn(7'h2A, 1'b1, 1'b0, 0, 0, 0, 0);

    ack = 1'($urandom);
    run_txn(7'($urandom), 1'($urandom), ack, 16, 10, 0, 0);
    if (ack) do_hold(3, 0);

    ack = 1'($urandom);
    run_txn(7'($urandom), 1'($urandom), ack, 0, 0, 0, 50);
    if (ack) do_hold(2, 1);

    run_txn(7'($urandom), 1'($urandom), 1'b1, 0, 0, 1 + 18 * D + 1, 0);
    @(posedge FPGA_clk);
    #1;
    chk("post_rst", {scl_oe, sda_oe, busy, done, acked, nack}, 8'd0);

    ack = 1'($urandom);
    run_txn(7'($urandom), 1'($urandom), ack, 0, 0, 0, 0);
    if (ack) do_hold(1, 0);

    for (int n = 0; n < 6; n++) begin
      ack = 1'($urandom);
      run_txn(7'($urandom), 1'($urandom), ack,
              4 + 4 * $urandom_range(0, 8) + $urandom_range(0, 1),
              $urandom_range(0, 7), 0, 0);
      if (ack) do_hold($urandom_range(1, 4), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
